// File: rtl/dram_req_scheduler.sv
// dram_req_scheduler
//   Shares one DRAM request/response port (the input side of the DRAM
//   interleaver) among NUM_REQ requesters. Requests are arbitrated
//   round-robin with bounded burst ownership (up to MAX_BURST consecutive
//   accepts per requester). A tag FIFO records the issuer of every read so
//   in-order read responses are routed back to the right requester.
//   Interleaver mode changes are sequenced: new grants are blocked, the
//   outstanding reads drain, then the new config is pulsed out once.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_in              mode-change request (taken only while not busy)
//   cfg_busy            drain/apply sequence in progress
//   cfg_out             to interleaver config input; .valid is a 1-cycle pulse
//   req_in[]            per-requester request
//   req_grant_out       per-requester request accept
//   resp_out[]          per-requester read response
//   resp_grant_in       per-requester response accept
//   mem_req_out         request to the interleaver
//   mem_req_grant_in    interleaver request accept
//   mem_resp_in         response from the interleaver, in request order
//   mem_resp_grant_out  response accept towards the interleaver
//   outstanding         reads issued but not yet returned
//   err_orphan_resp     sticky: a response arrived with no read outstanding

typedef enum logic [1:0] {
  CHAN0_ONLY  = 2'd0,
  CHAN1_ONLY  = 2'd1,
  INTERLEAVED = 2'd2
} DramMode;

typedef struct packed {
  logic    valid;
  DramMode mode;
} DramInterleaverConfig;

typedef struct packed {
  logic        valid;
  logic        isWrite;
  logic [15:0] addr;
  logic [31:0] data;
} MemReq;

typedef struct packed {
  logic        valid;
  logic [31:0] data;
} MemResp;

module dram_req_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int MAX_BURST     = 4,
  parameter int LOG_TAG_DEPTH = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  DramInterleaverConfig     cfg_in,
  output logic                     cfg_busy,
  output DramInterleaverConfig     cfg_out,
  input  MemReq                    req_in [NUM_REQ],
  output logic [NUM_REQ-1:0]       req_grant_out,
  output MemResp                   resp_out [NUM_REQ],
  input  logic [NUM_REQ-1:0]       resp_grant_in,
  output MemReq                    mem_req_out,
  input  logic                     mem_req_grant_in,
  input  MemResp                   mem_resp_in,
  output logic                     mem_resp_grant_out,
  output logic [LOG_TAG_DEPTH:0]   outstanding,
  output logic                     err_orphan_resp
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH   = 1 << LOG_TAG_DEPTH;
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  localparam logic [IDX_W:0]         NUM_REQ_W   = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0]       LAST_IDX    = IDX_W'(NUM_REQ - 1);
  localparam logic [BURST_W-1:0]     MAX_BURST_W = BURST_W'(MAX_BURST);
  localparam logic [LOG_TAG_DEPTH:0] DEPTH_W     = (LOG_TAG_DEPTH+1)'(DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, APPLY} SchedState;

  SchedState              state_q, state_d;
  DramMode                mode_q, mode_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [BURST_W-1:0]     burstCnt_q, burstCnt_d;
  logic [IDX_W-1:0]       tagMem_q [DEPTH];
  logic [LOG_TAG_DEPTH-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [LOG_TAG_DEPTH:0] count_q, count_d;
  logic                   orphan_q, orphan_d;

  logic                   fifoFull, fifoEmpty;
  logic [NUM_REQ-1:0]     eligible, eligRot;
  logic                   found;
  logic [IDX_W-1:0]       offset, winner, head;
  logic [IDX_W:0]         winSum;
  logic                   accept, push, pop;

  function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] x);
    return (x == LAST_IDX) ? '0 : x + IDX_W'(1);
  endfunction

  assign fifoFull  = (count_q == DEPTH_W);
  assign fifoEmpty = (count_q == '0);
  assign head      = tagMem_q[rdPtr_q];

  // Round-robin search: rotate the eligibility vector so that bit 0 is the
  // current pointer, take the lowest set bit, then map back to an index.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_in[i].valid && (req_in[i].isWrite || !fifoFull);
    end
    eligRot = NUM_REQ'({eligible, eligible} >> ptr_q);
    found   = |eligRot;
    offset  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (eligRot[k]) offset = IDX_W'(k);
    end
    winSum = {1'b0, ptr_q} + {1'b0, offset};
    if (winSum >= NUM_REQ_W) winSum = winSum - NUM_REQ_W;
    winner = winSum[IDX_W-1:0];
  end

  // Request path is purely combinational; reset and the drain/apply states
  // force every request-side output idle.
  always_comb begin
    mem_req_out   = '0;
    req_grant_out = '0;
    accept        = 1'b0;
    push          = 1'b0;
    if (rst_n && state_q == RUN && found) begin
      mem_req_out           = req_in[winner];
      req_grant_out[winner] = mem_req_grant_in;
      accept                = mem_req_grant_in;
      push                  = mem_req_grant_in && !req_in[winner].isWrite;
    end
  end

  // Burst ownership: the pointer stays on a requester for MAX_BURST accepts.
  // A non-pointer winner takes ownership with one accept already counted,
  // except in pure round-robin mode where it is passed on immediately.
  always_comb begin
    ptr_d      = ptr_q;
    burstCnt_d = burstCnt_q;
    if (accept) begin
      if (winner == ptr_q) begin
        if (burstCnt_q + BURST_W'(1) == MAX_BURST_W) begin
          ptr_d      = nextIdx(winner);
          burstCnt_d = '0;
        end else begin
          burstCnt_d = burstCnt_q + BURST_W'(1);
        end
      end else if (MAX_BURST == 1) begin
        ptr_d      = nextIdx(winner);
        burstCnt_d = '0;
      end else begin
        ptr_d      = winner;
        burstCnt_d = BURST_W'(1);
      end
    end
  end

  // Response routing: the FIFO head owns the response port, so a stalled
  // requester blocks everyone behind it. With no read outstanding any
  // response is an orphan and is swallowed.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) resp_out[i] = '0;
    mem_resp_grant_out = 1'b0;
    pop                = 1'b0;
    orphan_d           = orphan_q;
    if (rst_n) begin
      if (!fifoEmpty) begin
        resp_out[head]     = mem_resp_in;
        mem_resp_grant_out = resp_grant_in[head];
        pop                = mem_resp_in.valid && resp_grant_in[head];
      end else if (mem_resp_in.valid) begin
        mem_resp_grant_out = 1'b1;
        orphan_d           = 1'b1;
      end
    end
  end

  always_comb begin
    wrPtr_d = push ? wrPtr_q + LOG_TAG_DEPTH'(1) : wrPtr_q;
    rdPtr_d = pop  ? rdPtr_q + LOG_TAG_DEPTH'(1) : rdPtr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (LOG_TAG_DEPTH+1)'(1);
      2'b01:   count_d = count_q - (LOG_TAG_DEPTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Mode-change sequencer. DRAIN waits on the post-update count so the
  // apply pulse follows the cycle of the last pop directly.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    unique case (state_q)
      RUN: begin
        if (cfg_in.valid) begin
          mode_d  = cfg_in.mode;
          state_d = DRAIN;
        end
      end
      DRAIN:   if (count_d == '0) state_d = APPLY;
      APPLY:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign cfg_busy        = (state_q != RUN);
  assign cfg_out.valid   = (state_q == APPLY);
  assign cfg_out.mode    = mode_q;
  assign outstanding     = count_q;
  assign err_orphan_resp = orphan_q;

  always_ff @(posedge clk) begin
    if (push) tagMem_q[wrPtr_q] <= winner;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      mode_q     <= CHAN0_ONLY;
      ptr_q      <= '0;
      burstCnt_q <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      orphan_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      ptr_q      <= ptr_d;
      burstCnt_q <= burstCnt_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      orphan_q   <= orphan_d;
    end
  end

endmodule

// File: tb/tb_dram_req_scheduler.sv
// tb_dram_req_scheduler
//   Directed bench for dram_req_scheduler. Two instances share all inputs:
//   dutA is pure round-robin (MAX_BURST=1), dutB uses bursts of 4. Both have
//   a 4-entry tag FIFO so the full condition is easy to reach.

module tb_dram_req_scheduler;

  typedef struct packed {
    logic       valid;
    logic [1:0] mode;
  } CfgT;

  typedef struct packed {
    logic        valid;
    logic        isWrite;
    logic [15:0] addr;
    logic [31:0] data;
  } ReqT;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } RespT;

  localparam logic [1:0] MODE_CHAN0 = 2'd0;
  localparam logic [1:0] MODE_CHAN1 = 2'd1;
  localparam logic [1:0] MODE_INTER = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n;
  CfgT        cfgIn;
  ReqT        reqIn [4];
  logic [3:0] respGrantIn;
  logic       memReqGrantIn;
  RespT       memRespIn;

  logic       cfgBusyA, cfgBusyB;
  CfgT        cfgOutA, cfgOutB;
  logic [3:0] reqGrantA, reqGrantB;
  RespT       respOutA [4];
  RespT       respOutB [4];
  ReqT        memReqOutA, memReqOutB;
  logic       memRespGrantA, memRespGrantB;
  logic [2:0] outstandingA, outstandingB;
  logic       errA, errB;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  dram_req_scheduler #(.NUM_REQ(4), .MAX_BURST(1), .LOG_TAG_DEPTH(2)) dutA (
    .clk(clk), .rst_n(rst_n), .cfg_in(cfgIn), .cfg_busy(cfgBusyA), .cfg_out(cfgOutA),
    .req_in(reqIn), .req_grant_out(reqGrantA), .resp_out(respOutA),
    .resp_grant_in(respGrantIn), .mem_req_out(memReqOutA),
    .mem_req_grant_in(memReqGrantIn), .mem_resp_in(memRespIn),
    .mem_resp_grant_out(memRespGrantA), .outstanding(outstandingA),
    .err_orphan_resp(errA)
  );

  dram_req_scheduler #(.NUM_REQ(4), .MAX_BURST(4), .LOG_TAG_DEPTH(2)) dutB (
    .clk(clk), .rst_n(rst_n), .cfg_in(cfgIn), .cfg_busy(cfgBusyB), .cfg_out(cfgOutB),
    .req_in(reqIn), .req_grant_out(reqGrantB), .resp_out(respOutB),
    .resp_grant_in(respGrantIn), .mem_req_out(memReqOutB),
    .mem_req_grant_in(memReqGrantIn), .mem_resp_in(memRespIn),
    .mem_resp_grant_out(memRespGrantB), .outstanding(outstandingB),
    .err_orphan_resp(errB)
  );

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Drive every DUT input for the coming cycle. Requester i always carries
  // address 0x100+i so the forwarded request identifies its source.
  task automatic applyStimulus(input logic [3:0] reqValid, input logic [3:0] reqWrite,
                               input logic memGrant, input logic respValid,
                               input logic [31:0] respData, input logic [3:0] respGrant,
                               input logic cfgValid, input logic [1:0] cfgMode);
    for (int i = 0; i < 4; i++) begin
      reqIn[i].valid   = reqValid[i];
      reqIn[i].isWrite = reqWrite[i];
      reqIn[i].addr    = 16'h0100 + 16'(i);
      reqIn[i].data    = 32'hA000_0000 + 32'(i);
    end
    memReqGrantIn   = memGrant;
    memRespIn.valid = respValid;
    memRespIn.data  = respData;
    respGrantIn     = respGrant;
    cfgIn.valid     = cfgValid;
    cfgIn.mode      = cfgMode;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic resetDuts();
    rst_n = 1'b0;
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, MODE_CHAN0);
    nextCycle();
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] validsB();
    return {respOutB[3].valid, respOutB[2].valid, respOutB[1].valid, respOutB[0].valid};
  endfunction

  function automatic logic [3:0] validsA();
    return {respOutA[3].valid, respOutA[2].valid, respOutA[1].valid, respOutA[0].valid};
  endfunction

  int burstExp [15] = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 2, 2, 2, 2, 0};

  initial begin
    rst_n = 1'b0;
    applyStimulus(4'hF, 4'h0, 1'b1, 1'b1, 32'h55, 4'hF, 1'b0, MODE_CHAN0);
    #3;
    // Reset values, with busy inputs to show the outputs stay forced idle.
    checkOutput("rst grantA", reqGrantA, 4'h0);
    checkOutput("rst grantB", reqGrantB, 4'h0);
    checkOutput("rst memReqB", memReqOutB, 50'h0);
    checkOutput("rst respValidB", validsB(), 4'h0);
    checkOutput("rst respGrantB", memRespGrantB, 1'b0);
    checkOutput("rst outstandingB", outstandingB, 3'd0);
    checkOutput("rst cfgBusyB", cfgBusyB, 1'b0);
    checkOutput("rst cfgOutB", cfgOutB, {1'b0, MODE_CHAN0});
    checkOutput("rst errB", errB, 1'b0);
    nextCycle();
    resetDuts();

    // Pure round-robin on dutA: four reads fill the FIFO in order 0,1,2,3.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'hF, 4'h0, 1'b1, 1'b0, 32'h0, 4'hF, 1'b0, MODE_CHAN0);
      #1;
      checkOutput($sformatf("rr grant %0d", k), reqGrantA, 4'b0001 << k);
      checkOutput($sformatf("rr addr %0d", k), memReqOutA.addr, 16'h0100 + 16'(k));
      nextCycle();
    end
    applyStimulus(4'hF, 4'h0, 1'b1, 1'b0, 32'h0, 4'hF, 1'b0, MODE_CHAN0);
    #1;
    checkOutput("rr full grant", reqGrantA, 4'h0);
    checkOutput("rr full outstanding", outstandingA, 3'd4);
    nextCycle();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'h0, 4'h0, 1'b1, 1'b1, 32'hD0 + 32'(k), 4'hF, 1'b0, MODE_CHAN0);
      #1;
      checkOutput($sformatf("rr resp route %0d", k), validsA(), 4'b0001 << k);
      checkOutput($sformatf("rr resp data %0d", k), respOutA[k].data, 32'hD0 + 32'(k));
      checkOutput($sformatf("rr resp grant %0d", k), memRespGrantA, 1'b1);
      nextCycle();
    end
    applyStimulus(4'hF, 4'h0, 1'b1, 1'b0, 32'h0, 4'hF, 1'b0, MODE_CHAN0);
    #1;
    checkOutput("rr wrap grant", reqGrantA, 4'b0001);
    checkOutput("rr drained", outstandingA, 3'd0);
    nextCycle();

    // Burst ownership on dutB with writes from requesters 0 and 2;
    // requester 0 drops out for one cycle at step 10.
    resetDuts();
    for (int k = 0; k < 15; k++) begin
      applyStimulus({2'b01, 1'b0, (k != 10)}, 4'b0101, 1'b1, 1'b0, 32'h0, 4'h0,
                    1'b0, MODE_CHAN0);
      #1;
      checkOutput($sformatf("burst grant %0d", k), reqGrantB, 4'b0001 << burstExp[k]);
      checkOutput($sformatf("burst addr %0d", k), memReqOutB.addr,
                  16'h0100 + 16'(burstExp[k]));
      nextCycle();
    end

    // Full tag FIFO on dutB: reads stall, the write on requester 3 proceeds.
    resetDuts();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'hF, 4'b1000, 1'b1, 1'b0, 32'h0, 4'hF, 1'b0, MODE_CHAN0);
      #1;
      checkOutput($sformatf("fill grant %0d", k), reqGrantB, 4'b0001);
      nextCycle();
    end
    applyStimulus(4'hF, 4'b1000, 1'b1, 1'b0, 32'h0, 4'hF, 1'b0, MODE_CHAN0);
    #1;
    checkOutput("full write grant", reqGrantB, 4'b1000);
    checkOutput("full write fwd", memReqOutB.isWrite, 1'b1);
    checkOutput("full outstanding", outstandingB, 3'd4);
    nextCycle();

    // Pop one response, then hold one with resp_grant_in low for the head.
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b1, 32'hE0, 4'hF, 1'b0, MODE_CHAN0);
    #1;
    checkOutput("pop route", validsB(), 4'b0001);
    checkOutput("pop data", respOutB[0].data, 32'hE0);
    nextCycle();
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b1, 32'hE9, 4'b1110, 1'b0, MODE_CHAN0);
    #1;
    checkOutput("hold grant", memRespGrantB, 1'b0);
    checkOutput("hold route", validsB(), 4'b0001);
    nextCycle();

    // Mode change with three reads outstanding.
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'hF, 1'b1, MODE_INTER);
    #1;
    checkOutput("cfg take outstanding", outstandingB, 3'd3);
    checkOutput("cfg take busy", cfgBusyB, 1'b0);
    nextCycle();
    applyStimulus(4'b1000, 4'b1000, 1'b1, 1'b0, 32'h0, 4'hF, 1'b1, MODE_CHAN1);
    #1;
    checkOutput("drain busy", cfgBusyB, 1'b1);
    checkOutput("drain grant", reqGrantB, 4'h0);
    checkOutput("drain memReq valid", memReqOutB.valid, 1'b0);
    nextCycle();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b1000, 4'b1000, 1'b1, 1'b1, 32'hE1 + 32'(k), 4'hF, 1'b0, MODE_CHAN0);
      #1;
      checkOutput($sformatf("drain pop route %0d", k), validsB(), 4'b0001);
      checkOutput($sformatf("drain pop cfg %0d", k), cfgOutB.valid, 1'b0);
      checkOutput($sformatf("drain pop grant %0d", k), reqGrantB, 4'h0);
      nextCycle();
    end
    applyStimulus(4'b1000, 4'b1000, 1'b1, 1'b0, 32'h0, 4'hF, 1'b0, MODE_CHAN0);
    #1;
    checkOutput("apply cfgOut", cfgOutB, {1'b1, MODE_INTER});
    checkOutput("apply busy", cfgBusyB, 1'b1);
    checkOutput("apply grant", reqGrantB, 4'h0);
    nextCycle();
    applyStimulus(4'b1000, 4'b1000, 1'b1, 1'b0, 32'h0, 4'hF, 1'b0, MODE_CHAN0);
    #1;
    checkOutput("resume cfg valid", cfgOutB.valid, 1'b0);
    checkOutput("resume busy", cfgBusyB, 1'b0);
    checkOutput("resume grant", reqGrantB, 4'b1000);
    nextCycle();

    // Orphan response with nothing outstanding.
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b1, 32'hBAD, 4'h0, 1'b0, MODE_CHAN0);
    #1;
    checkOutput("orphan drop grant", memRespGrantB, 1'b1);
    checkOutput("orphan no route", validsB(), 4'h0);
    checkOutput("orphan err before", errB, 1'b0);
    nextCycle();
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, MODE_CHAN0);
    #1;
    checkOutput("orphan err set", errB, 1'b1);
    nextCycle();

    // Reset in the middle of a drain with two reads outstanding.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(4'b0001, 4'h0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, MODE_CHAN0);
      nextCycle();
    end
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, MODE_INTER);
    nextCycle();
    applyStimulus(4'b0001, 4'h0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, MODE_CHAN0);
    #1;
    checkOutput("mid drain busy", cfgBusyB, 1'b1);
    checkOutput("mid drain outstanding", outstandingB, 3'd2);
    checkOutput("orphan err sticky", errB, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async rst busy", cfgBusyB, 1'b0);
    checkOutput("async rst outstanding", outstandingB, 3'd0);
    checkOutput("async rst err", errB, 1'b0);
    checkOutput("async rst grant", reqGrantB, 4'h0);
    checkOutput("async rst memReq", memReqOutB, 50'h0);
    checkOutput("async rst cfgOut", cfgOutB, {1'b0, MODE_CHAN0});
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(4'b0001, 4'h0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, MODE_CHAN0);
    #1;
    checkOutput("post rst grant", reqGrantB, 4'b0001);
    checkOutput("post rst cfg valid", cfgOutB.valid, 1'b0);
    nextCycle();
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, MODE_CHAN0);
    #1;
    checkOutput("post rst no pulse", cfgOutB.valid, 1'b0);
    checkOutput("post rst outstanding", outstandingB, 3'd1);
    nextCycle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
